serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//   Parallel-to-serial frame transmitter. Drives the single-bit serial line that our
//   sampling flop blocks capture: start bit, WIDTH data bits LSB-first, optional parity,
//   and stop bit(s), each held for CLKS_PER_BIT clocks. Sits upstream of the capture flop
//   in the gate-level/SDF delay-mode test harness and generates deterministic stimulus.
// PARAMETERS
//   WIDTH         8  data bits per frame (>=1)
//   CLKS_PER_BIT  4  clock cycles each serial bit is held (>=1; 1 is legal)
//   STOP_BITS     1  number of stop bits (1 or 2)
// PORTS
//   clk       in   1      single clock, all logic on posedge
//   rst       in   1      synchronous reset, active-high
//   tx_data   in   WIDTH  word to send, sampled only on accept
//   tx_valid  in   1      upstream has a word
//   tx_ready  out  1      block can accept (high only in IDLE)
//   sd        out  1      serial data line, idle level 1
//   busy      out  1      frame in progress (START..STOP)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, sd=1, tx_ready=1, busy=0, counters=0,
//     shift reg=0. Reset mid-frame aborts the frame; idle values from the next cycle.
//   - All outputs are registered; no combinational input-to-output path.
//   - Accept: tx_valid && tx_ready at a posedge -> tx_data latched into shift reg,
//     state->START. tx_data/tx_valid ignored outside IDLE.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     START: sd=0 for CLKS_PER_BIT cycles, busy=1, tx_ready=0.
//     DATA: bit i (i=0..WIDTH-1) on sd for CLKS_PER_BIT cycles each; shift right.
//     PARITY (only with PARITY_EN): even parity = XOR of latched word, CLKS_PER_BIT cycles.
//     STOP: sd=1 for STOP_BITS*CLKS_PER_BIT cycles; then IDLE.
//   - Cycle counter 0..CLKS_PER_BIT-1 (width $clog2(CLKS_PER_BIT), min 1); wraps to 0
//     at bit boundary; bit index 0..WIDTH-1 advances on wrap.
//   - Timing: first start-bit cycle is the cycle after accept. Frame length
//     F=(1+WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, P=1 with PARITY_EN else 0.
//     tx_ready=1 and busy=0 in the cycle after the last stop cycle.
//   - Back-to-back: valid held high -> next word accepted in that IDLE cycle; exactly one
//     idle cycle (sd=1) between consecutive frames.
//   - tx_valid low in IDLE: sd stays 1 indefinitely; no spurious start bit.
// CONFIGURATION
//   PARITY_EN defined: PARITY state inserted between DATA and STOP, even parity,
//     F grows by CLKS_PER_BIT.
//   PARITY_EN undefined: no PARITY state, no parity logic; DATA goes straight to STOP.
// TESTING  (WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
//   1. rst=1 for 2 cycles, tx_valid=1 -> sd=1, tx_ready=1, busy=0; no accept while rst=1.
//   2. Send 0xA5 -> sd: 0 x4, then 1,0,1,0,0,1,0,1 x4 each, 1 x4; total 40 cycles;
//      tx_ready=1 on cycle 41.
//   3. Back-to-back 0x00 then 0xFF, valid held -> 2nd accepted in idle cycle; exactly 1
//      sd=1 cycle between frames; 0xFF data bits all 1.
//   4. Change tx_data to 0x12 during 0x5A frame -> line carries 0x5A unchanged.
//   5. rst=1 at cycle 15 of 0xC3 frame -> next cycle sd=1, tx_ready=1, busy=0; then send
//      0x3C -> clean 40-cycle frame.
//   6. PARITY_EN, send 0x07 -> parity bit 1 after data, 44-cycle frame; 0x03 -> parity 0.

Source files
------------

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-to-serial frame transmitter (optional PARITY_EN macro adds an even-parity bit)
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sd,
    output logic             busy
);

    // Cycle counter and bit index widths never collapse to zero bits.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             sd_q;
    logic             busy_q;
    logic             ready_q;
`ifdef PARITY_EN
    logic             parity_q;
`endif

    logic cnt_wrap;

    // Next shift-register contents when the line advances to the following data bit.
    always_comb begin
        shift_d  = shift_q >> 1;
        cnt_wrap = (cnt_q == CNT_LAST);
    end

    // Frame sequencer; the line value for the next cycle is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            sd_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tx_valid) begin
                        shift_q  <= tx_data;
`ifdef PARITY_EN
                        parity_q <= ^tx_data;
`endif
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        sd_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_wrap) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        sd_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_wrap) begin
                        cnt_q <= '0;
                        if (bit_q == DATA_LAST) begin
                            bit_q   <= '0;
`ifdef PARITY_EN
                            sd_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            sd_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_d;
                            sd_q    <= shift_d[0];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef PARITY_EN
                S_PARITY: begin
                    if (cnt_wrap) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        sd_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_wrap) begin
                        cnt_q <= '0;
                        if (bit_q == STOP_LAST) begin
                            bit_q   <= '0;
                            sd_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    sd_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign sd       = sd_q;
    assign busy     = busy_q;
    assign tx_ready = ready_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx with a frame-level reference model
module tb_serial_frame_tx;

    localparam int WIDTH        = 8;
    localparam int CLKS_PER_BIT = 4;
    localparam int STOP_BITS    = 1;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NSYM = 1 + WIDTH + P + STOP_BITS;
    localparam int FL   = NSYM * CLKS_PER_BIT;

    // Expected outputs packed as {sd, busy, tx_ready}.
    localparam logic [2:0] IDLE_V = 3'b101;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             sd;
    logic             busy;

    int errors = 0;
    int checks = 0;

    logic [2:0] mq[$];
    logic [2:0] cur = IDLE_V;
    int         acc_cnt = 0;

    serial_frame_tx #(
        .WIDTH(WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .sd(sd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Builds the whole line waveform of one frame from the word, symbol by symbol.
    task automatic build_frame(input logic [WIDTH-1:0] d);
        logic [NSYM-1:0] syms;
        syms = '0;
        syms[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) syms[1+i] = d[i];
        if (P == 1) syms[1+WIDTH] = ^d;
        for (int s = 0; s < STOP_BITS; s++) syms[1+WIDTH+P+s] = 1'b1;
        for (int s = 0; s < NSYM; s++)
            for (int c = 0; c < CLKS_PER_BIT; c++)
                mq.push_back({syms[s], 1'b1, 1'b0});
    endtask

    // One clock: advance the model on the edge, then compare the DUT 1 time unit later.
    task automatic step();
        logic prev_ready;
        @(posedge clk);
        prev_ready = cur[0];
        if (rst) begin
            mq.delete();
            cur = IDLE_V;
        end else if (mq.size() != 0) begin
            cur = mq.pop_front();
        end else if (prev_ready && tx_valid) begin
            build_frame(tx_data);
            acc_cnt++;
            cur = mq.pop_front();
        end else begin
            cur = IDLE_V;
        end
        #1;
        check("sd", int'(sd), int'(cur[2]));
        check("busy", int'(busy), int'(cur[1]));
        check("tx_ready", int'(tx_ready), int'(cur[0]));
    endtask

    task automatic send_one(input logic [WIDTH-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [NSYM-1:0] a5_pat;
        int n_busy;
        int n_idle;
        int n_ones;
        int a0;

        // Reset with valid high: nothing may be accepted.
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        step();
        step();
        check("rst_ready", int'(tx_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_sd", int'(sd), 1);
        rst      = 1'b0;
        tx_valid = 1'b0;
        step();

        // Single 0xA5 frame against a hand-written line pattern.
`ifdef PARITY_EN
        a5_pat = 11'b10101001010;
`else
        a5_pat = 10'b1101001010;
`endif
        send_one(8'hA5);
        check("model_len_a5", mq.size() + 1, (P == 1) ? 44 : 40);
        n_busy = 0;
        for (int k = 0; k < FL; k++) begin
            check("a5_line", int'(sd), int'(a5_pat[k / CLKS_PER_BIT]));
            if (busy) n_busy++;
            step();
        end
        check("a5_len", n_busy, (P == 1) ? 44 : 40);
        check("a5_end_ready", int'(tx_ready), 1);
        check("a5_end_busy", int'(busy), 0);
        repeat (3) step();
        check("idle_sd", int'(sd), 1);

        // Back-to-back 0x00 then 0xFF with valid held.
        a0       = acc_cnt;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hFF;
        n_idle  = 0;
        n_ones  = 0;
        for (int k = 0; k <= 2 * FL; k++) begin
            if (!busy) n_idle++;
            if (k > FL && sd) n_ones++;
            if (acc_cnt - a0 >= 2) tx_valid = 1'b0;
            step();
        end
        tx_valid = 1'b0;
        check("b2b_accepts", acc_cnt - a0, 2);
        check("b2b_gap", n_idle, 1);
        check("ff_ones", n_ones, 36);
        repeat (2) step();

        // Input word changes mid-frame; the line must keep 0x5A.
        send_one(8'h5A);
        repeat (10) step();
        tx_data = 8'h12;
        repeat (FL) step();

        // Reset in the middle of a 0xC3 frame, then a clean 0x3C frame.
        send_one(8'hC3);
        repeat (14) step();
        rst = 1'b1;
        step();
        check("abort_sd", int'(sd), 1);
        check("abort_ready", int'(tx_ready), 1);
        check("abort_busy", int'(busy), 0);
        rst = 1'b0;
        step();
        send_one(8'h3C);
        n_busy = 0;
        for (int k = 0; k < FL; k++) begin
            if (busy) n_busy++;
            step();
        end
        check("3c_len", n_busy, FL);
        step();

`ifdef PARITY_EN
        send_one(8'h07);
        repeat (CLKS_PER_BIT * (1 + WIDTH)) step();
        check("par_07", int'(sd), 1);
        repeat (FL) step();
        send_one(8'h03);
        repeat (CLKS_PER_BIT * (1 + WIDTH)) step();
        check("par_03", int'(sd), 0);
        repeat (FL) step();
`endif

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = WIDTH'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            step();
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        repeat (FL + 2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
